// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - byte-serial memory bus arbiter between instruction fetch and load/store unit
module mem_bus_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_en,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_data,
    input  logic        lsb_en,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_rdy,
    output logic [31:0] lsb_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state_q, state_n;
    logic [1:0]  k_q, k_n;
    logic [1:0]  last_q, last_n;
    logic        drain_q, drain_n;
    logic        owner_lsb_q, owner_lsb_n;
    logic        prio_lsb_q, prio_lsb_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [31:0] rbuf_q, rbuf_n;
    logic        if_rdy_q, if_rdy_n;
    logic        lsb_rdy_q, lsb_rdy_n;
    logic [31:0] if_data_q, if_data_n;
    logic [31:0] lsb_rdata_q, lsb_rdata_n;

    logic [31:0] byte_addr;
    logic        io_stall;
    logic        if_req, lsb_req, grant_lsb, grant_if;
    logic [1:0]  lsb_last;
    logic [1:0]  sel_idx;
    logic [31:0] rbuf_ins;

    assign byte_addr = addr_q + {30'd0, k_q};
    assign io_stall  = (state_q == WRITE) && (byte_addr[17:16] == 2'b11) && io_buffer_full;
    assign if_req    = if_en && !if_rdy_q && !flush;
    assign lsb_req   = lsb_en && !lsb_rdy_q && !flush;
    assign grant_lsb = lsb_req && (!if_req || prio_lsb_q);
    assign grant_if  = if_req && !grant_lsb;
    assign lsb_last  = (lsb_size == 2'd0) ? 2'd0 : (lsb_size == 2'd1) ? 2'd1 : 2'd3;

    // Memory answers one cycle after the address, so byte k lands one cycle behind k.
    always_comb begin
        sel_idx  = drain_q ? last_q : (k_q - 2'd1);
        rbuf_ins = rbuf_q;
        rbuf_ins[{sel_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_n     = state_q;
        k_n         = k_q;
        last_n      = last_q;
        drain_n     = drain_q;
        owner_lsb_n = owner_lsb_q;
        prio_lsb_n  = prio_lsb_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rbuf_n      = rbuf_q;
        if_rdy_n    = 1'b0;
        lsb_rdy_n   = 1'b0;
        if_data_n   = if_data_q;
        lsb_rdata_n = lsb_rdata_q;
        mem_a       = 32'd0;
        mem_wr      = 1'b0;
        mem_dout    = 8'd0;

        case (state_q)
            IDLE: begin
                k_n     = 2'd0;
                drain_n = 1'b0;
                rbuf_n  = 32'd0;
                if (grant_lsb) begin
                    state_n     = lsb_wr ? WRITE : READ;
                    owner_lsb_n = 1'b1;
                    prio_lsb_n  = 1'b0;
                    addr_n      = lsb_addr;
                    wdata_n     = lsb_wdata;
                    last_n      = lsb_last;
                end else if (grant_if) begin
                    state_n     = READ;
                    owner_lsb_n = 1'b0;
                    prio_lsb_n  = 1'b1;
                    addr_n      = if_addr;
                    last_n      = 2'd3;
                end
            end
            READ: begin
                if (!drain_q) begin
                    mem_a = byte_addr;
                end
                if (flush) begin
                    state_n = IDLE;
                    k_n     = 2'd0;
                    drain_n = 1'b0;
                end else if (drain_q) begin
                    state_n = IDLE;
                    k_n     = 2'd0;
                    drain_n = 1'b0;
                    rbuf_n  = rbuf_ins;
                    if (owner_lsb_q) begin
                        lsb_rdata_n = rbuf_ins;
                        lsb_rdy_n   = 1'b1;
                    end else begin
                        if_data_n = rbuf_ins;
                        if_rdy_n  = 1'b1;
                    end
                end else begin
                    if (k_q != 2'd0) begin
                        rbuf_n = rbuf_ins;
                    end
                    if (k_q == last_q) begin
                        drain_n = 1'b1;
                    end else begin
                        k_n = k_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                if (!io_stall) begin
                    mem_a    = byte_addr;
                    mem_wr   = rdy_in;
                    mem_dout = wdata_q[{k_q, 3'b000} +: 8];
                    if (k_q == last_q) begin
                        state_n   = IDLE;
                        k_n       = 2'd0;
                        lsb_rdy_n = 1'b1;
                    end else begin
                        k_n = k_q + 2'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = 2'd0;
                drain_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            last_q      <= 2'd0;
            drain_q     <= 1'b0;
            owner_lsb_q <= 1'b0;
            prio_lsb_q  <= 1'b1;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rbuf_q      <= 32'd0;
            if_rdy_q    <= 1'b0;
            lsb_rdy_q   <= 1'b0;
            if_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            state_q     <= state_n;
            k_q         <= k_n;
            last_q      <= last_n;
            drain_q     <= drain_n;
            owner_lsb_q <= owner_lsb_n;
            prio_lsb_q  <= prio_lsb_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            rbuf_q      <= rbuf_n;
            if_rdy_q    <= if_rdy_n;
            lsb_rdy_q   <= lsb_rdy_n;
            if_data_q   <= if_data_n;
            lsb_rdata_q <= lsb_rdata_n;
        end
    end

    assign if_rdy    = if_rdy_q;
    assign lsb_rdy   = lsb_rdy_q;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_en = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_rdy;
    logic [31:0] if_data;
    logic        lsb_en = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [1:0]  lsb_size = 2'd0;
    logic [31:0] lsb_addr = 32'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic        lsb_rdy;
    logic [31:0] lsb_rdata;

    logic [7:0] mem [0:4095];
    int tests = 0;
    int fails = 0;

    mem_bus_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_en(if_en), .if_addr(if_addr),
        .if_rdy(if_rdy), .if_data(if_data), .lsb_en(lsb_en), .lsb_wr(lsb_wr),
        .lsb_size(lsb_size), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_rdy(lsb_rdy), .lsb_rdata(lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    // One-cycle-latency memory that stalls together with the global ready.
    always @(posedge clk_in) begin
        if (rdy_in) mem_din <= mem[mem_a[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_in);
        #1;
    endtask

    task automatic nxtn(input int n);
        for (int i = 0; i < n; i++) nxt();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = i[7:0] ^ 8'h5A;
        mem[256] = 8'h13;
        mem[257] = 8'h00;
        mem[258] = 8'h00;
        mem[259] = 8'h00;

        nxtn(2);
        rst_in = 1'b0;
        #1;
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_if_rdy", {31'd0, if_rdy}, 32'd0);
        check("rst_lsb_rdy", {31'd0, lsb_rdy}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_lsb_rdata", lsb_rdata, 32'd0);

        // Word fetch at 0x100
        if_en = 1'b1; if_addr = 32'h100;
        nxt(); if_en = 1'b0; #1;
        check("fetch_a0", mem_a, 32'h100);
        check("fetch_wr0", {31'd0, mem_wr}, 32'd0);
        nxt(); check("fetch_a1", mem_a, 32'h101);
        nxt(); check("fetch_a2", mem_a, 32'h102);
        nxt(); check("fetch_a3", mem_a, 32'h103);
        nxt(); check("fetch_rdy_early", {31'd0, if_rdy}, 32'd0);
        nxt(); check("fetch_rdy", {31'd0, if_rdy}, 32'd1);
        check("fetch_data", if_data, 32'h00000013);
        nxt(); check("fetch_rdy_pulse", {31'd0, if_rdy}, 32'd0);
        check("fetch_data_hold", if_data, 32'h00000013);
        check("idle_mem_a", mem_a, 32'd0);

        // Fetch across the 32-bit address wrap
        if_en = 1'b1; if_addr = 32'hFFFF_FFFE;
        nxt(); if_en = 1'b0; #1;
        check("wrap_a0", mem_a, 32'hFFFF_FFFE);
        nxt(); check("wrap_a1", mem_a, 32'hFFFF_FFFF);
        nxt(); check("wrap_a2", mem_a, 32'h0000_0000);
        nxt(); check("wrap_a3", mem_a, 32'h0000_0001);
        nxtn(2); check("wrap_rdy", {31'd0, if_rdy}, 32'd1);
        check("wrap_data", if_data, 32'h5B5AA5A4);

        // Arbitration straight after reset
        rst_in = 1'b1;
        nxt(); rst_in = 1'b0; #1;
        check("rst2_if_data", if_data, 32'd0);
        if_en = 1'b1; if_addr = 32'h100;
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h40;
        nxt(); check("arb_lsb_first", mem_a, 32'h40);
        nxtn(2); check("arb_lsb_rdy", {31'd0, lsb_rdy}, 32'd1);
        check("arb_lsb_byte", lsb_rdata, 32'h0000001A);
        nxt(); check("arb_if_next", mem_a, 32'h100);
        check("arb_lsb_rdy_off", {31'd0, lsb_rdy}, 32'd0);
        if_en = 1'b0; lsb_en = 1'b0;
        nxtn(5); check("arb_if_rdy", {31'd0, if_rdy}, 32'd1);
        nxt();
        if_en = 1'b1; lsb_en = 1'b1;
        nxt(); check("rr_lsb_wins", mem_a, 32'h40);
        if_en = 1'b0; lsb_en = 1'b0;
        nxtn(2); check("rr_lsb_rdy", {31'd0, lsb_rdy}, 32'd1);
        nxt();
        if_en = 1'b1; lsb_en = 1'b1;
        nxt(); check("rr_if_wins", mem_a, 32'h100);
        if_en = 1'b0; lsb_en = 1'b0;
        nxtn(5); check("rr_if_rdy", {31'd0, if_rdy}, 32'd1);
        nxt();

        // Byte store to I/O space while the TX buffer is full
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
        io_buffer_full = 1'b1;
        nxt(); lsb_en = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
            check("io_stall_a", mem_a, 32'd0);
            nxt();
        end
        io_buffer_full = 1'b0; #1;
        check("io_wr", {31'd0, mem_wr}, 32'd1);
        check("io_a", mem_a, 32'h30000);
        check("io_dout", {24'd0, mem_dout}, 32'h41);
        check("io_rdy_early", {31'd0, lsb_rdy}, 32'd0);
        nxt(); check("io_rdy", {31'd0, lsb_rdy}, 32'd1);
        check("io_single_wr", {31'd0, mem_wr}, 32'd0);
        nxt();

        // Flush in the second cycle of a word fetch
        if_en = 1'b1; if_addr = 32'h40;
        nxt(); if_en = 1'b0; #1;
        check("flush_a0", mem_a, 32'h40);
        nxt(); flush = 1'b1;
        nxt(); flush = 1'b0; #1;
        check("flush_idle", mem_a, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("flush_no_rdy", {31'd0, if_rdy}, 32'd0);
            nxt();
        end
        check("flush_data_hold", if_data, 32'h00000013);

        // Flush during a half store completes the store
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h200; lsb_wdata = 32'h0000C3D2;
        nxt(); lsb_en = 1'b0; flush = 1'b1; #1;
        check("fst_wr0", {31'd0, mem_wr}, 32'd1);
        check("fst_a0", mem_a, 32'h200);
        check("fst_d0", {24'd0, mem_dout}, 32'hD2);
        nxt();
        check("fst_wr1", {31'd0, mem_wr}, 32'd1);
        check("fst_a1", mem_a, 32'h201);
        check("fst_d1", {24'd0, mem_dout}, 32'hC3);
        nxt(); flush = 1'b0; #1;
        check("fst_rdy", {31'd0, lsb_rdy}, 32'd1);
        nxt();

        // Global ready low for two cycles inside a word load
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h40;
        nxt(); lsb_en = 1'b0; #1;
        check("frz_a0", mem_a, 32'h40);
        nxt(); rdy_in = 1'b0; #1;
        check("frz_a1", mem_a, 32'h41);
        check("frz_wr", {31'd0, mem_wr}, 32'd0);
        nxt(); check("frz_a1_hold", mem_a, 32'h41);
        nxt(); rdy_in = 1'b1; #1;
        check("frz_a1_resume", mem_a, 32'h41);
        nxt(); check("frz_a2", mem_a, 32'h42);
        nxt(); check("frz_a3", mem_a, 32'h43);
        nxt(); check("frz_rdy_late", {31'd0, lsb_rdy}, 32'd0);
        nxt(); check("frz_rdy", {31'd0, lsb_rdy}, 32'd1);
        check("frz_rdata", lsb_rdata, 32'h19181B1A);
        rdy_in = 1'b0;
        nxt(); check("frz_rdy_held", {31'd0, lsb_rdy}, 32'd1);
        rdy_in = 1'b1;
        nxt(); check("frz_rdy_drop", {31'd0, lsb_rdy}, 32'd0);

        // Reset in the middle of a word store
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h300; lsb_wdata = 32'h11223344;
        nxt(); lsb_en = 1'b0; #1;
        check("rw_wr0", {31'd0, mem_wr}, 32'd1);
        check("rw_d0", {24'd0, mem_dout}, 32'h44);
        rdy_in = 1'b0; #1;
        check("rw_rdy_low_wr", {31'd0, mem_wr}, 32'd0);
        rdy_in = 1'b1; #1;
        nxt(); check("rw_a1", mem_a, 32'h301);
        check("rw_d1", {24'd0, mem_dout}, 32'h33);
        rst_in = 1'b1;
        nxt(); rst_in = 1'b0; #1;
        check("rw_rst_wr", {31'd0, mem_wr}, 32'd0);
        check("rw_rst_a", mem_a, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("rw_rst_no_rdy", {31'd0, lsb_rdy}, 32'd0);
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: clk_in (rising edge), rst_in.
REQ-002 Ports SHALL be (name direction width meaning):
- clk_in in 1: clock.
- rst_in in 1: synchronous reset, active high.
- rdy_in in 1: global ready; low = freeze.
- flush in 1: misprediction flush.
- io_buffer_full in 1: UART TX buffer full.
- mem_din in 8: memory read byte.
- mem_dout out 8: memory write byte.
- mem_a out 32: byte address.
- mem_wr out 1: 1 = write.
- if_en in 1: fetch request.
- if_addr in 32: fetch address.
- if_rdy out 1: fetch done pulse.
- if_data out 32: fetched word.
- lsb_en in 1: load/store request.
- lsb_wr in 1: 1 = store.
- lsb_size in 2: 0 = byte, 1 = half, 2 = word (3 = word).
- lsb_addr in 32: access address.
- lsb_wdata in 32: store data, low bytes first.
- lsb_rdy out 1: done pulse.
- lsb_rdata out 32: load data, zero-extended.

Function
REQ-003 SHALL use states IDLE, READ, WRITE and a 2-bit byte counter k; N = 4 for fetch, N = 1/2/4 for LSB by lsb_size.
REQ-004 In IDLE with no grant, outputs SHALL be mem_a = 0, mem_wr = 0, mem_dout = 0.
REQ-005 Grant is evaluated only in IDLE at a rising edge E0:
- Only one requester active: that requester wins.
- Both active: the requester that did not win the previous grant wins (round-robin); after reset, LSB has priority.
REQ-006 A requester's en SHALL be ignored during the cycle its rdy is high, and during any cycle flush is high.
REQ-007 Read, accepted at E0:
- mem_a = addr+k, mem_wr = 0 during the cycle after edge E_k, for k = 0..N-1.
- Byte k is sampled from mem_din at edge E_(k+2) into result bits [8k+7:8k].
- rdy is high and data valid for exactly the one cycle after E_(N+1).
- The arbiter returns to IDLE at that same edge and may grant again at E_(N+2).
REQ-008 Write, accepted at E0:
- mem_a = addr+k, mem_wr = 1, mem_dout = lsb_wdata[8k+7:8k] during the cycle after E_k.
- lsb_rdy pulses for one cycle after E_N.
REQ-009 Address and write data SHALL be latched at E0; later changes on the request inputs are ignored until the next grant.
REQ-010 I/O write stall: when a write's address has bits [17:16] = 2'b11 and io_buffer_full is high:
- mem_wr and mem_a are driven 0.
- k does not advance.
- The byte is re-issued once io_buffer_full is low.
REQ-011 Flush:
- Flush high at an edge during any READ (fetch or LSB) SHALL abort it: IDLE next cycle, no rdy pulse, k reset.
- A WRITE in progress SHALL complete normally despite flush.
REQ-012 When rdy_in is low:
- All state, counters and latched data SHALL hold.
- mem_wr SHALL be forced 0.
- No byte SHALL be sampled.
- A pending rdy pulse SHALL be held until rdy_in returns high.
REQ-013 Byte address increments SHALL be 32-bit modular (0xFFFFFFFF+1 = 0).
REQ-014 if_data and lsb_rdata SHALL hold their last value between pulses; for N < 4, the unfilled upper bytes SHALL read 0.

Reset
REQ-015 rst_in high at an edge, in any state, SHALL abort any transaction and give:
- State IDLE, k = 0.
- All outputs 0.
- Round-robin pointer favouring LSB.
REQ-016 rst_in SHALL take precedence over rdy_in low and over flush.

Verification
REQ-017 The bench SHALL cover:
- Fetch at 0x100, memory bytes 13,00,00,00 → addresses 0x100..0x103 in consecutive cycles; if_rdy in cycle 5 after acceptance with if_data = 0x00000013.
- Simultaneous if_en and lsb_en after reset → LSB granted first; fetch granted at the first IDLE edge after lsb_rdy; if both then re-request → LSB wins.
- Byte store 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then one write of 0x41; lsb_rdy one cycle later.
- Flush in the 2nd cycle of a word fetch → no if_rdy, IDLE next cycle; flush during a half store to 0x200 → both bytes written, lsb_rdy pulses.
- rdy_in low for 2 cycles mid word-load → mem_a/k frozen, mem_wr = 0; lsb_rdata correct; rdy arrives 2 cycles later than nominal.
- rst_in mid-write → next cycle mem_wr = 0, mem_a = 0, no lsb_rdy.
